// File: rtl/spine_router.sv
// Spine router: five buffered inputs (four leaves plus the uplink) feeding five
// registered outputs, with per-output round-robin arbitration and drop accounting.
module spine_router #(
   parameter int unsigned DWIDTH     = 16,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter logic [3:0]  GROUP_ID   = 4'b0110
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                arb_enable,
   input  logic [4*DWIDTH-1:0] leaf_in_data,
   input  logic [3:0]          leaf_in_valid,
   input  logic [23:0]         leaf_dest_addr,
   output logic [3:0]          leaf_in_ready,
   output logic [4*DWIDTH-1:0] leaf_out_data,
   output logic [3:0]          leaf_out_valid,
   input  logic [3:0]          leaf_out_ready,
   input  logic [DWIDTH-1:0]   up_in_data,
   input  logic                up_in_valid,
   input  logic [5:0]          up_dest_addr,
   output logic                up_in_ready,
   output logic [DWIDTH-1:0]   up_out_data,
   output logic [5:0]          up_out_dest_addr,
   output logic                up_out_valid,
   input  logic                up_out_ready,
   output logic [4:0]          fifo_full,
   output logic [4:0]          fifo_empty,
   output logic [7:0]          drop_count,
   output logic                busy
);
   localparam int unsigned EW = DWIDTH + 6;
   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

   logic [EW-1:0]     mem [5][FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr [5];
   logic [AW-1:0]     rd_ptr [5];
   logic [AW:0]       count [5];
   logic [EW-1:0]     in_entry [5];
   logic [EW-1:0]     head [5];
   logic [4:0]        in_valid;
   logic [4:0]        wr_en;
   logic [4:0]        pop;
   logic [4:0]        misroute;
   logic [2:0]        target [5];
   logic [4:0]        req [5];
   logic [4:0]        grant;
   logic [2:0]        gidx [5];
   logic [2:0]        rr_ptr [5];
   logic [4:0]        slot_valid;
   logic [4:0]        slot_ready;
   logic [DWIDTH-1:0] slot_data [5];
   logic [5:0]        up_dest_q;
   logic [3:0]        n_drops;
   logic [8:0]        drop_sum;

   always_comb begin
      for (int unsigned i = 0; i < 4; i++) begin
         in_valid[i] = leaf_in_valid[i];
         in_entry[i] = {leaf_dest_addr[i*6 +: 6], leaf_in_data[i*DWIDTH +: DWIDTH]};
      end
      in_valid[4] = up_in_valid;
      in_entry[4] = {up_dest_addr, up_in_data};
   end

   // Head decode: local group goes to a leaf, foreign goes up, except that a
   // foreign packet arriving on the uplink has nowhere to go and is discarded.
   always_comb begin
      for (int unsigned i = 0; i < 5; i++) begin
         fifo_empty[i] = (count[i] == '0);
         fifo_full[i]  = (count[i] == FULL_CNT);
         wr_en[i]      = in_valid[i] && !fifo_full[i];
         head[i]       = mem[i][rd_ptr[i]];
         if (head[i][EW-1 -: 4] == GROUP_ID) begin
            target[i]   = {1'b0, head[i][EW-5 -: 2]};
            misroute[i] = 1'b0;
         end else begin
            target[i]   = 3'd4;
            misroute[i] = (i == 4) && !fifo_empty[i];
         end
      end
   end

   assign slot_ready = {up_out_ready, leaf_out_ready};

   always_comb begin
      int unsigned idx;
      idx = 0;
      pop = misroute & {5{arb_enable}};
      for (int unsigned o = 0; o < 5; o++) begin
         grant[o] = 1'b0;
         gidx[o]  = '0;
         for (int unsigned i = 0; i < 5; i++)
            req[o][i] = !fifo_empty[i] && !misroute[i] && (target[i] == 3'(o));
         if (arb_enable && (!slot_valid[o] || slot_ready[o])) begin
            for (int unsigned k = 1; k <= 5; k++) begin
               idx = (32'(rr_ptr[o]) + k) % 5;
               if (!grant[o] && req[o][idx]) begin
                  grant[o] = 1'b1;
                  gidx[o]  = 3'(idx);
               end
            end
         end
         if (grant[o])
            pop[gidx[o]] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < 5; i++)
         if (wr_en[i])
            mem[i][wr_ptr[i]] <= in_entry[i];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < 5; i++) begin
            wr_ptr[i] <= '0;
            rd_ptr[i] <= '0;
            count[i]  <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < 5; i++) begin
            if (wr_en[i])
               wr_ptr[i] <= wr_ptr[i] + 1'b1;
            if (pop[i])
               rd_ptr[i] <= rd_ptr[i] + 1'b1;
            count[i] <= count[i] + (AW+1)'(wr_en[i]) - (AW+1)'(pop[i]);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         slot_valid <= '0;
         up_dest_q  <= '0;
         for (int unsigned o = 0; o < 5; o++) begin
            slot_data[o] <= '0;
            rr_ptr[o]    <= 3'd4;
         end
      end else begin
         for (int unsigned o = 0; o < 5; o++) begin
            if (grant[o]) begin
               slot_valid[o] <= 1'b1;
               slot_data[o]  <= head[gidx[o]][DWIDTH-1:0];
               rr_ptr[o]     <= gidx[o];
            end else if (slot_ready[o]) begin
               slot_valid[o] <= 1'b0;
            end
         end
         if (grant[4])
            up_dest_q <= head[gidx[4]][EW-1 -: 6];
      end
   end

   // Overflow drops on every input plus an uplink misroute can land together.
   always_comb begin
      n_drops = '0;
      for (int unsigned i = 0; i < 5; i++)
         n_drops = n_drops + 4'(in_valid[i] & fifo_full[i]);
      n_drops  = n_drops + 4'(misroute[4] & arb_enable);
      drop_sum = {1'b0, drop_count} + 9'(n_drops);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         drop_count <= '0;
      else
         drop_count <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
   end

   always_comb begin
      for (int unsigned o = 0; o < 4; o++)
         leaf_out_data[o*DWIDTH +: DWIDTH] = slot_data[o];
   end

   assign leaf_out_valid   = slot_valid[3:0];
   assign up_out_valid     = slot_valid[4];
   assign up_out_data      = slot_data[4];
   assign up_out_dest_addr = up_dest_q;
   assign leaf_in_ready    = ~fifo_full[3:0];
   assign up_in_ready      = ~fifo_full[4];
   assign busy             = !(&fifo_empty) || (|slot_valid);

endmodule

// File: tb/tb_spine_router.sv
// Self-checking bench for spine_router: routing vector table, a per-output
// scoreboard fed at stimulus time, and multi-cycle corner-case sequences.
module tb_spine_router;
   localparam int unsigned DW  = 16;
   localparam logic [3:0]  GID = 4'b0110;

   logic          clk = 1'b0;
   logic          reset;
   logic          arb_enable;
   logic [4*DW-1:0] leaf_in_data;
   logic [3:0]    leaf_in_valid;
   logic [23:0]   leaf_dest_addr;
   logic [3:0]    leaf_in_ready;
   logic [4*DW-1:0] leaf_out_data;
   logic [3:0]    leaf_out_valid;
   logic [3:0]    leaf_out_ready;
   logic [DW-1:0] up_in_data;
   logic          up_in_valid;
   logic [5:0]    up_dest_addr;
   logic          up_in_ready;
   logic [DW-1:0] up_out_data;
   logic [5:0]    up_out_dest_addr;
   logic          up_out_valid;
   logic          up_out_ready;
   logic [4:0]    fifo_full;
   logic [4:0]    fifo_empty;
   logic [7:0]    drop_count;
   logic          busy;

   spine_router #(.DWIDTH(DW), .FIFO_DEPTH(8), .GROUP_ID(GID)) dut (
      .clk(clk), .reset(reset), .arb_enable(arb_enable),
      .leaf_in_data(leaf_in_data), .leaf_in_valid(leaf_in_valid),
      .leaf_dest_addr(leaf_dest_addr), .leaf_in_ready(leaf_in_ready),
      .leaf_out_data(leaf_out_data), .leaf_out_valid(leaf_out_valid),
      .leaf_out_ready(leaf_out_ready),
      .up_in_data(up_in_data), .up_in_valid(up_in_valid),
      .up_dest_addr(up_dest_addr), .up_in_ready(up_in_ready),
      .up_out_data(up_out_data), .up_out_dest_addr(up_out_dest_addr),
      .up_out_valid(up_out_valid), .up_out_ready(up_out_ready),
      .fifo_full(fifo_full), .fifo_empty(fifo_empty),
      .drop_count(drop_count), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [DW-1:0] data;
      logic [5:0]    dest;
   } exp_t;

   typedef struct {
      int            src;
      logic [5:0]    dest;
      logic [DW-1:0] data;
      int            exp_out;
      logic [7:0]    exp_drops;
   } vec_t;

   exp_t sbq [5][$];
   int   n_pass  = 0;
   int   n_total = 0;

   logic [4:0] ov;
   logic [4:0] ordy;
   assign ov   = {up_out_valid, leaf_out_valid};
   assign ordy = {up_out_ready, leaf_out_ready};

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp)
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      else
         n_pass++;
   endtask

   function automatic logic [DW-1:0] out_data(input int o);
      if (o == 4) return up_out_data;
      return leaf_out_data[o*DW +: DW];
   endfunction

   function automatic int qsize();
      int s = 0;
      for (int o = 0; o < 5; o++) s += sbq[o].size();
      return s;
   endfunction

   // Every accepted output beat must match the oldest expectation for that port.
   always @(negedge clk) begin
      if (reset === 1'b1) begin
         for (int o = 0; o < 5; o++) begin
            if (ov[o] && ordy[o]) begin
               if (sbq[o].size() == 0) begin
                  n_total++;
                  $display("FAIL out%0d_unexpected: got data %0h expected no packet", o, out_data(o));
               end else begin
                  exp_t e;
                  e = sbq[o].pop_front();
                  check($sformatf("out%0d_data", o), 32'(out_data(o)), 32'(e.data));
                  if (o == 4)
                     check("up_dest", 32'(up_out_dest_addr), 32'(e.dest));
               end
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic clear_in();
      leaf_in_valid = '0;
      up_in_valid   = 1'b0;
   endtask

   task automatic drive(input int src, input logic [5:0] dest, input logic [DW-1:0] data);
      if (src < 4) begin
         leaf_in_data[src*DW +: DW] = data;
         leaf_dest_addr[src*6 +: 6] = dest;
         leaf_in_valid[src]         = 1'b1;
      end else begin
         up_in_data   = data;
         up_dest_addr = dest;
         up_in_valid  = 1'b1;
      end
   endtask

   task automatic push(input int o, input logic [5:0] dest, input logic [DW-1:0] data);
      exp_t e;
      e.data = data;
      e.dest = dest;
      sbq[o].push_back(e);
   endtask

   task automatic do_reset();
      reset          = 1'b0;
      arb_enable     = 1'b1;
      leaf_out_ready = '1;
      up_out_ready   = 1'b1;
      clear_in();
      for (int o = 0; o < 5; o++) sbq[o].delete();
      @(posedge clk);
      #2;
      reset = 1'b1;
   endtask

   task automatic wait_drain(input string name, input int max);
      int n = 0;
      while (qsize() != 0 && n < max) begin
         step();
         n++;
      end
      step();
      check(name, 32'(qsize()), 0);
   endtask

   vec_t vt [8];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      vt[0] = '{0, {GID, 2'd2}, 16'hA5A5, 2,  8'd0};
      vt[1] = '{1, 6'b000100,   16'h1111, 4,  8'd0};
      vt[2] = '{4, 6'b000100,   16'h1234, -1, 8'd1};
      vt[3] = '{4, {GID, 2'd3}, 16'hBEEF, 3,  8'd1};
      vt[4] = '{3, {GID, 2'd3}, 16'h3333, 3,  8'd1};
      vt[5] = '{2, 6'b111111,   16'h2222, 4,  8'd1};
      vt[6] = '{4, {GID, 2'd0}, 16'h0F0F, 0,  8'd1};
      vt[7] = '{1, {GID, 2'd1}, 16'h5A5A, 1,  8'd1};

      leaf_in_data = '0; leaf_dest_addr = '0; up_in_data = '0; up_dest_addr = '0;
      do_reset();

      check("rst_fifo_empty", 32'(fifo_empty), 32'h1F);
      check("rst_fifo_full",  32'(fifo_full), 0);
      check("rst_in_ready",   32'({up_in_ready, leaf_in_ready}), 32'h1F);
      check("rst_out_valid",  32'(ov), 0);
      check("rst_leaf_data",  leaf_out_data[31:0] | leaf_out_data[63:32], 0);
      check("rst_up_data",    32'({up_out_dest_addr, up_out_data}), 0);
      check("rst_drops",      32'(drop_count), 0);
      check("rst_busy",       32'(busy), 0);

      // Single-packet routing: one-cycle latency, one-cycle valid, cumulative drops.
      for (int v = 0; v < 8; v++) begin
         drive(vt[v].src, vt[v].dest, vt[v].data);
         if (vt[v].exp_out >= 0) push(vt[v].exp_out, vt[v].dest, vt[v].data);
         step();
         clear_in();
         check($sformatf("vec%0d_not_early", v), 32'(ov), 0);
         check($sformatf("vec%0d_busy_hi", v), 32'(busy), 1);
         step();
         check($sformatf("vec%0d_valid", v), 32'(ov),
               (vt[v].exp_out >= 0) ? (32'd1 << vt[v].exp_out) : 32'd0);
         check($sformatf("vec%0d_drops", v), 32'(drop_count), 32'(vt[v].exp_drops));
         step();
         check($sformatf("vec%0d_valid_gone", v), 32'(ov), 0);
         check($sformatf("vec%0d_busy_lo", v), 32'(busy), 0);
      end
      wait_drain("vec_drain", 4);

      // Four sources contending for leaf 2: expected order 0,1,3,4 repeating.
      do_reset();
      for (int c = 0; c < 4; c++) begin
         for (int s = 0; s < 5; s++) begin
            if (s != 2) begin
               drive(s, {GID, 2'd2}, 16'(c * 16 + s));
               push(2, {GID, 2'd2}, 16'(c * 16 + s));
            end
         end
         step();
      end
      clear_in();
      wait_drain("rr_drain", 40);
      check("rr_drops", 32'(drop_count), 0);

      // Backpressure on leaf 0: slot plus full FIFO, then an overflow drop.
      do_reset();
      leaf_out_ready[0] = 1'b0;
      for (int p = 0; p < 9; p++) begin
         drive(2, {GID, 2'd0}, 16'hC000 + 16'(p));
         push(0, {GID, 2'd0}, 16'hC000 + 16'(p));
         step();
      end
      check("bp_full",      32'(fifo_full), 32'h04);
      check("bp_in_ready",  32'(leaf_in_ready[2]), 0);
      check("bp_slot_hold", 32'({leaf_out_valid[0], leaf_out_data[15:0]}), 32'h1C000);
      drive(2, {GID, 2'd0}, 16'hDEAD);
      step();
      clear_in();
      check("bp_drop",       32'(drop_count), 1);
      check("bp_still_full", 32'(fifo_full), 32'h04);
      leaf_out_ready[0] = 1'b1;
      wait_drain("bp_drain", 20);
      check("bp_empty", 32'(fifo_empty), 32'h1F);

      // Arbitration disabled: packets stay queued, then stream out one per cycle.
      do_reset();
      arb_enable = 1'b0;
      for (int p = 0; p < 3; p++) begin
         drive(1, {GID, 2'd3}, 16'hE000 + 16'(p));
         push(3, {GID, 2'd3}, 16'hE000 + 16'(p));
         step();
      end
      clear_in();
      step();
      step();
      check("arb_off_valid", 32'(ov), 0);
      check("arb_off_held",  32'(fifo_empty[1]), 0);
      arb_enable = 1'b1;
      for (int p = 0; p < 3; p++) begin
         step();
         check($sformatf("arb_on_beat%0d", p), 32'(ov), 32'h08);
      end
      step();
      check("arb_on_done", 32'(ov), 0);
      wait_drain("arb_drain", 4);

      // Reset mid-burst discards everything asynchronously.
      do_reset();
      leaf_out_ready[1] = 1'b0;
      for (int s = 0; s < 5; s++) drive(s, {GID, 2'd1}, 16'hF000 + 16'(s));
      step();
      clear_in();
      step();
      check("mid_slot_loaded", 32'(ov), 32'h02);
      reset = 1'b0;
      #1;
      check("mid_rst_valid", 32'(ov), 0);
      check("mid_rst_empty", 32'(fifo_empty), 32'h1F);
      check("mid_rst_busy",  32'(busy), 0);
      step();
      reset = 1'b1;
      leaf_out_ready = '1;
      for (int n = 0; n < 8; n++) begin
         step();
         check($sformatf("mid_quiet%0d", n), 32'(ov), 0);
      end
      check("mid_final_empty", 32'(fifo_empty), 32'h1F);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/spine_router.md
# spine_router

Spine-side counterpart of the leaf router in each GPU group. It receives packets that leaf routers send up their spine links, buffers them per input, and decodes the 6-bit destination address. Each packet is forwarded down to the addressed leaf or out the inter-group uplink, with round-robin arbitration per output. One instance sits at each spine position of a group and faces four leaf routers plus one uplink.

## Interface
- DWIDTH, 16, payload width
- FIFO_DEPTH, 8, entries per input FIFO (power of two, ≥2)
- GROUP_ID, 4'b0110, this group's ID, compared against dest_addr[5:2]
- clk  input  1  sole clock, rising edge
- reset  input  1  asynchronous, active-low reset
- arb_enable  input  1  1 = grants allowed; 0 = hold all outputs' arbitration (FIFOs still accept)
- leaf_in_data  input  4*DWIDTH  packed per leaf i at [i*DWIDTH +: DWIDTH]
- leaf_in_valid  input  4  per-leaf write strobe
- leaf_dest_addr  input  24  packed 6 bits per leaf
- leaf_in_ready  output  4  per-leaf FIFO not full
- leaf_out_data  output  4*DWIDTH  packets down to leaf i
- leaf_out_valid  output  4  held until accepted
- leaf_out_ready  input  4  leaf accepts (leaves tie to 1)
- up_in_data / up_in_valid / up_dest_addr / up_in_ready  in/in/in/out  DWIDTH/1/6/1  uplink ingress
- up_out_data / up_out_dest_addr / up_out_valid / up_out_ready  out/out/out/in  DWIDTH/6/1/1  uplink egress
- fifo_full, fifo_empty  output  5  per input; bit 4 = uplink
- drop_count  output  8  saturating count of dropped packets
- busy  output  1  any FIFO non-empty or any out_valid high

## Operation
- Input FIFO entry = {dest_addr, data}, DWIDTH+6 bits. One FIFO per input, 5 total.
- Write when in_valid && !full. in_valid while full drops the packet and increments drop_count.
- Destination decode on FIFO head:
  - dest[5:2]==GROUP_ID → leaf output dest[1:0].
  - Otherwise → uplink output.
  - Head from uplink input with foreign group: misroute. It is popped without forwarding and increments drop_count.
- Hairpin (leaf i → leaf i) is legal and forwarded.
- Each output has a registered data/valid slot. The slot is free when !out_valid || out_ready.
- Per output, requesters are inputs whose non-empty head decodes to that output.
- Round-robin pointer per output. Priority starts at last granted input + 1, mod 5.
- Grant only when arb_enable=1 and the slot is free. The granted head pops and loads the slot in the same edge. The pointer updates to the granted index.
- Each head targets exactly one output, so at most one pop per FIFO per cycle. All 5 outputs may load in the same cycle.
- drop_count saturates at 8'hFF. Two or more drops in one cycle add the full count, still saturating.
- Simultaneous write and pop on a full FIFO: pop frees the entry, but the write is still dropped (ready = !full is registered-state based).
- Simultaneous write and pop on an empty FIFO: the write lands and the pop cannot occur.

## Timing
- Reset (reset=0, async), all values:
  - FIFOs empty: fifo_empty=5'h1F, fifo_full=0, in_ready all 1.
  - All out_valid=0; out_data and up_out_dest_addr 0.
  - RR pointers =4, so input 0 has first priority.
  - drop_count=0, busy=0.
- Reset mid-operation discards all buffered and in-flight packets immediately; outputs drop valid asynchronously.
- Latency, idle path: write at edge T → head visible after T → slot loaded at edge T+1, i.e. out_valid visible one cycle after the input beat.
- Backpressure: out_valid && !out_ready holds data/valid stable. That output grants nothing; other outputs continue.
- Throughput: one packet per output per cycle when out_ready=1.
- arb_enable falling: already-valid slots still complete their handshake; no new loads.

## Test plan
- Leaf0 sends data 16'hA5A5, dest {GROUP_ID,2'd2}, 1 cycle → leaf_out_valid[2]=1 with 16'hA5A5 exactly 1 cycle later for 1 cycle; busy returns 0.
- Leaves 0,1,3 and uplink all send to leaf 2 in one cycle, repeated 4 times → leaf 2 receives order 0,1,3,4,0,1,3,4,… with no losses; drop_count=0.
- Leaf1 sends dest 6'b0001_00 (foreign group) → up_out_valid with up_out_dest_addr=6'b000100. Uplink sends the same address → dropped, drop_count=1.
- leaf_out_ready[0]=0, leaf2 sends 9 packets to leaf 0 back-to-back:
  - 1 packet sits in the slot, 8 in the FIFO; fifo_full[2]=1.
  - A 10th packet is dropped: drop_count=1.
  - After release, 9 packets arrive in order.
- arb_enable=0 while 3 packets are queued → no out_valid and FIFOs hold. Re-enable → delivery resumes, 1 per cycle.
- Assert reset mid-burst with 5 packets buffered → all out_valid=0 and fifo_empty=5'h1F immediately. After release nothing is emitted.
